// File: rtl/loader_write_queue.sv
// Loader-to-SDRAM write queue.
// Buffers {addr, data} bytes from the iNES loader and replays them to SDRAM
// port A, issuing at most one write per slot pulse. Each issued write is held
// on mem_* from one slot pulse to the next so the SDRAM mux sees a full slot.
module loader_write_queue #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned ADDR_W     = 22
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_wr,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [7:0]            in_data,
  input  logic                  slot,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle,
  output logic                  overflow,
  output logic [ADDR_W-1:0]     wr_count
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned EntryW = ADDR_W + 8;
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [EntryW-1:0]     entry_t;

  // Storage is not reset: only entries between the pointers are ever read.
  entry_t store_q [Depth];

  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   wr_count_q, wr_count_d;

  logic   empty;
  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  logic   store_we;
  entry_t head;

  // Queue status and the push/pop/drop decisions for this cycle.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LevelFull);
    pop   = slot & ~empty;
    // A full queue can still accept a byte when the head leaves this cycle.
    push  = in_wr & (~full | pop);
    drop  = in_wr & full & ~pop;
    // clear outranks a push, so nothing is written into a flushed queue.
    store_we = push & ~clear;
    head     = store_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy, the SDRAM write register and status.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    overflow_d = overflow_q;
    wr_count_d = wr_count_q;

    if (clear) begin
      // Flush; mem_addr/mem_data keep their last value.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      mem_we_d   = 1'b0;
      overflow_d = 1'b0;
      wr_count_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = head[EntryW-1:8];
        mem_data_d = head[7:0];
        wr_count_d = wr_count_q + 1'b1;
      end else if (slot) begin
        // Nothing queued at this slot: release the port for a whole slot.
        mem_we_d = 1'b0;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[wr_ptr_q] <= {in_addr, in_data};
    end
  end

  // Control and output registers; reset drops mem_we asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      overflow_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      overflow_q <= overflow_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Output drive; idle tells the top level the queue has fully drained.
  always_comb begin
    mem_we   = mem_we_q;
    mem_addr = mem_addr_q;
    mem_data = mem_data_q;
    level    = level_q;
    overflow = overflow_q;
    wr_count = wr_count_q;
    idle     = (level_q == '0) & ~mem_we_q;
  end

endmodule

// File: tb/tb_loader_write_queue.sv
// Directed bench for loader_write_queue with a scoreboard queue model.
module tb_loader_write_queue;

  localparam int unsigned DepthLog2 = 2;
  localparam int unsigned AddrW     = 22;
  localparam int          Depth     = 4;

  typedef logic [AddrW+7:0] entry_t;

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             in_wr;
  logic [AddrW-1:0] in_addr;
  logic [7:0]       in_data;
  logic             slot;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [7:0]       mem_data;
  logic [DepthLog2:0] level;
  logic             idle;
  logic             overflow;
  logic [AddrW-1:0] wr_count;

  loader_write_queue #(
    .DEPTH_LOG2(DepthLog2),
    .ADDR_W    (AddrW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .in_wr   (in_wr),
    .in_addr (in_addr),
    .in_data (in_data),
    .slot    (slot),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .level   (level),
    .idle    (idle),
    .overflow(overflow),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: bytes the model expects the queue to hold, oldest first.
  entry_t           sb[$];
  logic             exp_we;
  logic [AddrW-1:0] exp_addr;
  logic [7:0]       exp_data;
  logic             exp_ovf;
  int               exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/mem_we"}, 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check({tag, "/mem_addr"}, 32'(mem_addr), 32'(exp_addr));
      check({tag, "/mem_data"}, 32'(mem_data), 32'(exp_data));
    end
    check({tag, "/level"}, 32'(level), 32'(sb.size()));
    check({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "/wr_count"}, 32'(wr_count), 32'(exp_cnt % (1 << AddrW)));
    check({tag, "/idle"}, 32'(idle), 32'((sb.size() == 0) && !exp_we));
  endtask

  task automatic model_reset();
    sb.delete();
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_cnt  = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic step(input string tag, input logic wr, input logic [AddrW-1:0] addr,
                      input logic [7:0] data, input logic slt);
    int     sz;
    logic   do_pop;
    entry_t e;
    in_wr   = wr;
    in_addr = addr;
    in_data = data;
    slot    = slt;
    @(posedge clk);
    sz     = sb.size();
    do_pop = slt && (sz > 0);
    if (do_pop) begin
      e        = sb.pop_front();
      exp_we   = 1'b1;
      exp_addr = e[AddrW+7:8];
      exp_data = e[7:0];
      exp_cnt++;
    end else if (slt) begin
      exp_we = 1'b0;
    end
    if (wr) begin
      if (sz < Depth || do_pop) sb.push_back({addr, data});
      else exp_ovf = 1'b1;
    end
    #1;
    in_wr = 1'b0;
    slot  = 1'b0;
    check_all(tag);
  endtask

  task automatic do_clear(input string tag, input logic slt, input logic wr);
    clear = 1'b1;
    slot  = slt;
    in_wr = wr;
    @(posedge clk);
    sb.delete();
    exp_we  = 1'b0;
    exp_ovf = 1'b0;
    exp_cnt = 0;
    #1;
    clear = 1'b0;
    slot  = 1'b0;
    in_wr = 1'b0;
    check_all(tag);
  endtask

  // Idle/drain cycles with a slot pulse every fourth clock.
  task automatic run_slots(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, (i % 4) == 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    in_wr   = 1'b0;
    in_addr = '0;
    in_data = '0;
    slot    = 1'b0;
    model_reset();

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset/mem_addr", 32'(mem_addr), 32'h0);
    check("reset/mem_data", 32'(mem_data), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_slots("idle", 12);

    // Single write, then a slot three clocks later.
    step("single_wr", 1'b1, 22'h000010, 8'hA5, 1'b0);
    step("single_gap", 1'b0, '0, '0, 1'b0);
    step("single_gap", 1'b0, '0, '0, 1'b0);
    step("single_slot", 1'b0, '0, '0, 1'b1);
    check("single/addr", 32'(mem_addr), 32'h10);
    check("single/data", 32'(mem_data), 32'hA5);
    step("single_hold", 1'b0, '0, '0, 1'b0);
    step("single_hold", 1'b0, '0, '0, 1'b0);
    step("single_hold", 1'b0, '0, '0, 1'b0);
    check("single/held_we", 32'(mem_we), 32'h1);
    step("single_end", 1'b0, '0, '0, 1'b1);
    check("single/we_off", 32'(mem_we), 32'h0);
    check("single/count", 32'(wr_count), 32'h1);

    // Empty queue with write and slot together: no bypass.
    step("nobypass", 1'b1, 22'h000020, 8'h5A, 1'b1);
    check("nobypass/we", 32'(mem_we), 32'h0);
    run_slots("nobypass_drain", 8);

    // Burst of four, drained in order.
    do_clear("burst_clr", 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step("burst_wr", 1'b1, 22'(32'h100 + i), 8'(8'h11 * (i + 1)), 1'b0);
    check("burst/peak", 32'(level), 32'h4);
    run_slots("burst_drain", 20);
    check("burst/count", 32'(wr_count), 32'h4);
    check("burst/ovf", 32'(overflow), 32'h0);

    // Overflow: six writes into a four-deep queue.
    do_clear("ovf_clr", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step("ovf_wr", 1'b1, 22'(32'h200 + i), 8'(8'hC0 + i), 1'b0);
    check("ovf/level", 32'(level), 32'h4);
    check("ovf/flag", 32'(overflow), 32'h1);
    run_slots("ovf_drain", 20);
    check("ovf/count", 32'(wr_count), 32'h4);
    check("ovf/sticky", 32'(overflow), 32'h1);
    do_clear("ovf_unclr", 1'b0, 1'b0);
    check("ovf/cleared", 32'(overflow), 32'h0);

    // Full queue with push and pop in the same cycle.
    for (int i = 0; i < 4; i++)
      step("pp_fill", 1'b1, 22'(32'h300 + i), 8'(8'h60 + i), 1'b0);
    step("pp_both", 1'b1, 22'h3FFFFF, 8'h99, 1'b1);
    check("pp/level", 32'(level), 32'h4);
    check("pp/ovf", 32'(overflow), 32'h0);
    check("pp/addr", 32'(mem_addr), 32'h300);
    run_slots("pp_drain", 24);

    // Clear together with slot mid-drain.
    for (int i = 0; i < 3; i++)
      step("clr_fill", 1'b1, 22'(32'h400 + i), 8'(8'h70 + i), 1'b0);
    step("clr_pop", 1'b0, '0, '0, 1'b1);
    do_clear("clr_mid", 1'b1, 1'b1);
    check("clr/we", 32'(mem_we), 32'h0);
    run_slots("clr_after", 8);

    // Asynchronous reset mid-drain, between clock edges.
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1'b1, 22'(32'h500 + i), 8'(8'h80 + i), 1'b0);
    step("rst_pop", 1'b0, '0, '0, 1'b1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst/addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_slots("rst_after", 8);
    step("rst_wr", 1'b1, 22'h000600, 8'h3C, 1'b0);
    run_slots("rst_drain", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
